// File: rtl/scs8hd_pwrsw_seq.sv
// Power-switch sequencer for one switchable scs8hd domain: staggered header enables,
// power-good wait, isolation/reset release, reverse power-down and fault capture.
module scs8hd_pwrsw_seq #(
  parameter int unsigned NGRP    = 4,
  parameter int unsigned STAGGER = 8,
  parameter int unsigned PGTO    = 255,
  parameter int unsigned RSTDLY  = 4
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            pwr_req,
  input  logic            pg_in,
  output logic [NGRP-1:0] sw_en,
  output logic            iso_en,
  output logic            dom_resetb,
  output logic            pwr_ack,
  output logic            err
);

  localparam int unsigned SPAN_MAX = (STAGGER > RSTDLY) ? STAGGER : RSTDLY;
  localparam int unsigned CNT_MAX  = (PGTO > SPAN_MAX) ? PGTO : SPAN_MAX;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_OFF, S_RAMP_UP, S_WAIT_PG, S_RST_REL, S_ON, S_PRE_DOWN, S_RAMP_DOWN, S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pg_meta;
  logic          pg_s;

  // Two-flop synchronizer for the asynchronous rail monitor output.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
    end else begin
      pg_meta <= pg_in;
      pg_s    <= pg_meta;
    end
  end

  // Sequencer; the shared down-counter is reloaded on every timed step.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= S_OFF;
      cnt        <= '0;
      sw_en      <= '0;
      iso_en     <= 1'b1;
      dom_resetb <= 1'b0;
      pwr_ack    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      case (state)
        S_OFF: begin
          if (pwr_req) begin
            state <= S_RAMP_UP;
            sw_en <= NGRP'(1);
            cnt   <= CW'(STAGGER - 1);
          end
        end
        S_RAMP_UP: begin
          if (&sw_en) begin
            state <= S_WAIT_PG;
            cnt   <= CW'(PGTO - 1);
          end else if (cnt == '0) begin
            sw_en <= (sw_en << 1) | NGRP'(1);
            cnt   <= CW'(STAGGER - 1);
          end
        end
        S_WAIT_PG: begin
          if (pg_s) begin
            state  <= S_RST_REL;
            iso_en <= 1'b0;
            cnt    <= CW'(RSTDLY - 1);
          end else if (cnt == '0) begin
            state      <= S_ERR;
            sw_en      <= '0;
            iso_en     <= 1'b1;
            dom_resetb <= 1'b0;
            pwr_ack    <= 1'b0;
            err        <= 1'b1;
          end
        end
        S_RST_REL: begin
          if (cnt == '0) begin
            state      <= S_ON;
            dom_resetb <= 1'b1;
            pwr_ack    <= 1'b1;
          end
        end
        S_ON: begin
          // Rail loss outranks a simultaneous power-down request.
          if (!pg_s) begin
            state      <= S_ERR;
            sw_en      <= '0;
            iso_en     <= 1'b1;
            dom_resetb <= 1'b0;
            pwr_ack    <= 1'b0;
            err        <= 1'b1;
          end else if (!pwr_req) begin
            state      <= S_PRE_DOWN;
            dom_resetb <= 1'b0;
            pwr_ack    <= 1'b0;
          end
        end
        S_PRE_DOWN: begin
          state  <= S_RAMP_DOWN;
          iso_en <= 1'b1;
          cnt    <= '0;
        end
        S_RAMP_DOWN: begin
          if (cnt == '0) begin
            sw_en <= sw_en >> 1;
            cnt   <= CW'(STAGGER - 1);
            if ((sw_en >> 1) == '0) state <= S_OFF;
          end
        end
        S_ERR: begin
          if (!pwr_req) begin
            state <= S_OFF;
            err   <= 1'b0;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_scs8hd_pwrsw_seq.sv
// Bench for scs8hd_pwrsw_seq: timeline-based reference model checked every cycle,
// directed sequences with literal timing pins, then randomized request/power-good traffic.
module tb_scs8hd_pwrsw_seq;

  localparam int NG = 4;
  localparam int ST = 8;
  localparam int PT = 255;
  localparam int RD = 4;

  localparam int P_OFF = 0, P_UP = 1, P_WAIT = 2, P_REL = 3, P_ON = 4, P_PRE = 5,
                 P_DOWN = 6, P_FAULT = 7;

  logic          clk;
  logic          resetb;
  logic          pwr_req;
  logic          pg_in;
  logic [NG-1:0] sw_en;
  logic          iso_en;
  logic          dom_resetb;
  logic          pwr_ack;
  logic          err;

  int checks   = 0;
  int failures = 0;

  scs8hd_pwrsw_seq #(.NGRP(NG), .STAGGER(ST), .PGTO(PT), .RSTDLY(RD)) dut (
    .clk(clk), .resetb(resetb), .pwr_req(pwr_req), .pg_in(pg_in),
    .sw_en(sw_en), .iso_en(iso_en), .dom_resetb(dom_resetb),
    .pwr_ack(pwr_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: phase + cycles elapsed in phase + number of groups powered.
  int       m_ph   = P_OFF;
  int       m_t    = 0;
  int       m_on   = 0;
  bit       m_iso  = 1'b1;
  bit       m_rstb = 1'b0;
  bit       m_ack  = 1'b0;
  bit       m_err  = 1'b0;
  bit [1:0] m_sy   = 2'b00;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_ph = P_OFF; m_t = 0; m_on = 0;
      m_iso = 1'b1; m_rstb = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_sy = 2'b00;
    end else begin
      bit pgs;
      pgs  = m_sy[1];
      m_sy = {m_sy[0], pg_in};
      m_t  = m_t + 1;
      case (m_ph)
        P_OFF: if (pwr_req) begin m_ph = P_UP; m_t = 0; m_on = 1; end
        P_UP: begin
          if (m_t == (NG - 1) * ST + 1) begin m_ph = P_WAIT; m_t = 0; end
          else m_on = 1 + m_t / ST;
        end
        P_WAIT: begin
          if (pgs) begin m_ph = P_REL; m_t = 0; m_iso = 1'b0; end
          else if (m_t == PT) begin
            m_ph = P_FAULT; m_on = 0; m_iso = 1'b1; m_rstb = 1'b0; m_ack = 1'b0; m_err = 1'b1;
          end
        end
        P_REL: if (m_t == RD) begin m_ph = P_ON; m_rstb = 1'b1; m_ack = 1'b1; end
        P_ON: begin
          if (!pgs) begin
            m_ph = P_FAULT; m_on = 0; m_iso = 1'b1; m_rstb = 1'b0; m_ack = 1'b0; m_err = 1'b1;
          end else if (!pwr_req) begin
            m_ph = P_PRE; m_t = 0; m_rstb = 1'b0; m_ack = 1'b0;
          end
        end
        P_PRE: if (m_t == 1) begin m_ph = P_DOWN; m_t = 0; m_iso = 1'b1; end
        P_DOWN: begin
          m_on = NG - 1 - (m_t - 1) / ST;
          if (m_on == 0) m_ph = P_OFF;
        end
        P_FAULT: if (!pwr_req) begin m_ph = P_OFF; m_err = 1'b0; end
        default: m_ph = P_OFF;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [NG-1:0] exp_sw;
    exp_sw = NG'((1 << m_on) - 1);
    chk("model_sw_en",      32'(sw_en),      32'(exp_sw));
    chk("model_iso_en",     32'(iso_en),     32'(m_iso));
    chk("model_dom_resetb", 32'(dom_resetb), 32'(m_rstb));
    chk("model_pwr_ack",    32'(pwr_ack),    32'(m_ack));
    chk("model_err",        32'(err),        32'(m_err));
  endtask

  // One clock edge, then compare at the falling edge; inputs change after return.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sw_en"},      32'(sw_en),      32'h0);
    chk({tag, "_iso_en"},     32'(iso_en),     32'h1);
    chk({tag, "_dom_resetb"}, 32'(dom_resetb), 32'h0);
    chk({tag, "_pwr_ack"},    32'(pwr_ack),    32'h0);
    chk({tag, "_err"},        32'(err),        32'h0);
  endtask

  initial begin
    bit pg_good;
    int glitch;
    resetb = 1'b0; pwr_req = 1'b0; pg_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    cmp_model();
    resetb = 1'b1;
    repeat (2) tick();

    // Nominal power-up: pg_in rises between edges 30 and 31.
    pwr_req = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (e == 0)  chk("up_sw_e0",  32'(sw_en), 32'h1);
      if (e == 7)  chk("up_sw_e7",  32'(sw_en), 32'h1);
      if (e == 8)  chk("up_sw_e8",  32'(sw_en), 32'h3);
      if (e == 16) chk("up_sw_e16", 32'(sw_en), 32'h7);
      if (e == 24) chk("up_sw_e24", 32'(sw_en), 32'hf);
      if (e == 32) chk("up_iso_e32", 32'(iso_en), 32'h1);
      if (e == 33) chk("up_iso_e33", 32'(iso_en), 32'h0);
      if (e == 36) chk("up_ack_e36", 32'(pwr_ack), 32'h0);
      if (e == 37) begin
        chk("up_ack_e37",  32'(pwr_ack), 32'h1);
        chk("up_rstb_e37", 32'(dom_resetb), 32'h1);
      end
      if (e == 30) pg_in = 1'b1;
    end

    // Nominal power-down.
    pwr_req = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (e == 0) begin
        chk("dn_ack_e0",  32'(pwr_ack), 32'h0);
        chk("dn_rstb_e0", 32'(dom_resetb), 32'h0);
        chk("dn_iso_e0",  32'(iso_en), 32'h0);
      end
      if (e == 1)  chk("dn_iso_e1", 32'(iso_en), 32'h1);
      if (e == 2)  chk("dn_sw_e2",  32'(sw_en), 32'h7);
      if (e == 9)  chk("dn_sw_e9",  32'(sw_en), 32'h7);
      if (e == 10) chk("dn_sw_e10", 32'(sw_en), 32'h3);
      if (e == 18) chk("dn_sw_e18", 32'(sw_en), 32'h1);
      if (e == 25) chk("dn_sw_e25", 32'(sw_en), 32'h1);
      if (e == 26) chk("dn_sw_e26", 32'(sw_en), 32'h0);
    end

    // Power-good timeout: WAIT_PG at edge 25, fault at 25+255.
    pg_in = 1'b0;
    pwr_req = 1'b1;
    for (int e = 0; e <= 285; e++) begin
      tick();
      if (e == 279) chk("to_err_e279", 32'(err), 32'h0);
      if (e == 280) begin
        chk("to_err_e280", 32'(err), 32'h1);
        chk("to_sw_e280",  32'(sw_en), 32'h0);
        chk("to_iso_e280", 32'(iso_en), 32'h1);
      end
    end
    pwr_req = 1'b0;
    tick();
    chk("to_err_clear", 32'(err), 32'h0);
    repeat (3) tick();

    // Power-good loss while ON.
    pg_in = 1'b1;
    pwr_req = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (e == 30) chk("loss_ack_on", 32'(pwr_ack), 32'h1);
      if (e == 34) pg_in = 1'b0;
      if (e == 36) chk("loss_err_e36", 32'(err), 32'h0);
      if (e == 37) begin
        chk("loss_err_e37",  32'(err), 32'h1);
        chk("loss_sw_e37",   32'(sw_en), 32'h0);
        chk("loss_rstb_e37", 32'(dom_resetb), 32'h0);
        chk("loss_ack_e37",  32'(pwr_ack), 32'h0);
        pg_in = 1'b1;
      end
    end
    pwr_req = 1'b0;
    repeat (4) tick();

    // Request dropped mid-ramp: ramp completes, ON for one cycle, then power-down.
    pwr_req = 1'b1;
    for (int e = 0; e <= 62; e++) begin
      tick();
      if (e == 10) pwr_req = 1'b0;
      if (e == 30) chk("tog_ack_e30", 32'(pwr_ack), 32'h1);
      if (e == 31) chk("tog_ack_e31", 32'(pwr_ack), 32'h0);
      if (e == 32) chk("tog_iso_e32", 32'(iso_en), 32'h1);
      if (e == 57) chk("tog_sw_e57",  32'(sw_en), 32'h0);
    end

    // Asynchronous reset in the middle of RAMP_DOWN.
    pwr_req = 1'b1;
    repeat (35) tick();
    pwr_req = 1'b0;
    repeat (5) tick();
    chk("ar_sw_before", 32'(sw_en), 32'h7);
    #2 resetb = 1'b0;
    #1 chk_reset_vals("async_reset");
    tick();
    #1 resetb = 1'b1;
    repeat (2) tick();

    // Randomized request and power-good traffic.
    pg_good = 1'b1;
    glitch = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 59) == 0) pwr_req = ~pwr_req;
      if ($urandom_range(0, 149) == 0) pg_good = ~pg_good;
      if (glitch > 0) glitch = glitch - 1;
      else if ($urandom_range(0, 199) == 0) glitch = $urandom_range(1, 4);
      pg_in = pg_good && (glitch == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
